// File: rtl/alu_share_if.sv
// Bundle of every signal between the shared-ALU arbiter and its surroundings:
// the two requesters, the ALU instance and the response consumers.
// "master" is the surrounding environment (requesters + ALU), "slave" the arbiter.
interface alu_share_if #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 4
);
    // Request side
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [DATA_W-1:0] req_a0;
    logic [DATA_W-1:0] req_a1;
    logic [DATA_W-1:0] req_b0;
    logic [DATA_W-1:0] req_b1;
    logic [CTRL_W-1:0] req_ctrl0;
    logic [CTRL_W-1:0] req_ctrl1;
    logic [1:0]        req_cmp0;
    logic [1:0]        req_cmp1;

    // ALU side
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [CTRL_W-1:0] alu_ctrl;
    logic              alu_cmp_en;
    logic              alu_eq;
    logic [DATA_W-1:0] alu_result;
    logic              alu_zero;

    // Response side
    logic [1:0]        rsp_valid;
    logic [1:0]        rsp_ready;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_zero;
    logic              rsp_err;

    modport master (
        output req_valid, req_a0, req_a1, req_b0, req_b1,
               req_ctrl0, req_ctrl1, req_cmp0, req_cmp1,
               alu_result, alu_zero, rsp_ready,
        input  req_ready, alu_a, alu_b, alu_ctrl, alu_cmp_en, alu_eq,
               rsp_valid, rsp_result, rsp_zero, rsp_err
    );

    modport slave (
        input  req_valid, req_a0, req_a1, req_b0, req_b1,
               req_ctrl0, req_ctrl1, req_cmp0, req_cmp1,
               alu_result, alu_zero, rsp_ready,
        output req_ready, alu_a, alu_b, alu_ctrl, alu_cmp_en, alu_eq,
               rsp_valid, rsp_result, rsp_zero, rsp_err
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one ALU between the execute stage (req 0) and the
// branch/address unit (req 1). One operation at a time: accept in IDLE,
// evaluate for exactly one cycle in EXEC, hold the registered result in RESP
// until the owning requester takes it.
module alu_share_arbiter #(
    parameter int DATA_W  = 32,
    parameter int CTRL_W  = 4,
    parameter int N_LEGAL = 10
) (
    input  logic      clk,
    input  logic      rst_n,
    alu_share_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [CTRL_W:0] LEGAL_LIMIT = (CTRL_W+1)'(N_LEGAL);

    state_t            state_reg;
    state_t            state_next;
    logic              last_grant_reg;
    logic              owner_reg;
    logic [DATA_W-1:0] a_reg;
    logic [DATA_W-1:0] b_reg;
    logic [CTRL_W-1:0] ctrl_reg;
    logic [1:0]        cmp_reg;
    logic [DATA_W-1:0] result_reg;
    logic              zero_reg;
    logic              err_reg;

    logic [1:0]        grant_oh;
    logic              grant_id;
    logic              accept;
    logic              ctrl_legal;

    // Round-robin pick: a lone requester wins outright, a tie goes to the
    // requester that was not served last.
    always_comb begin
        grant_oh = 2'b00;
        grant_id = 1'b0;
        if (bus.req_valid == 2'b11) begin
            grant_id = ~last_grant_reg;
            grant_oh = last_grant_reg ? 2'b01 : 2'b10;
        end else if (bus.req_valid[0]) begin
            grant_id = 1'b0;
            grant_oh = 2'b01;
        end else if (bus.req_valid[1]) begin
            grant_id = 1'b1;
            grant_oh = 2'b10;
        end
    end

    // A grant is offered only in IDLE, so req_ready doubles as the handshake.
    assign accept     = (state_reg == IDLE) && (grant_oh != 2'b00);
    assign ctrl_legal = ({1'b0, ctrl_reg} < LEGAL_LIMIT);

    // Per-requester ready/valid; ready is also masked while reset is held so
    // no requester sees a phantom accept.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            assign bus.req_ready[gi] = rst_n && (state_reg == IDLE) && grant_oh[gi];
            assign bus.rsp_valid[gi] = (state_reg == RESP) && (owner_reg == 1'(gi));
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state: fixed IDLE -> EXEC -> RESP -> IDLE walk; RESP waits on the owner only.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (bus.rsp_ready[owner_reg]) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand latch at accept, result capture at the end of the EXEC cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_reg <= 1'b1;
            owner_reg      <= 1'b0;
            a_reg          <= '0;
            b_reg          <= '0;
            ctrl_reg       <= '0;
            cmp_reg        <= '0;
            result_reg     <= '0;
            zero_reg       <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            if (accept) begin
                owner_reg      <= grant_id;
                last_grant_reg <= grant_id;
                a_reg          <= grant_id ? bus.req_a1    : bus.req_a0;
                b_reg          <= grant_id ? bus.req_b1    : bus.req_b0;
                ctrl_reg       <= grant_id ? bus.req_ctrl1 : bus.req_ctrl0;
                cmp_reg        <= grant_id ? bus.req_cmp1  : bus.req_cmp0;
            end
            if (state_reg == EXEC) begin
                if (ctrl_legal) begin
                    result_reg <= bus.alu_result;
                    zero_reg   <= bus.alu_zero;
                    err_reg    <= 1'b0;
                end else begin
                    // Unknown opcode: ALU output is meaningless, report an error instead.
                    result_reg <= '0;
                    zero_reg   <= 1'b0;
                    err_reg    <= 1'b1;
                end
            end
        end
    end

    // ALU is fed only from the latched operands, so it stays quiet between ops.
    assign bus.alu_a      = a_reg;
    assign bus.alu_b      = b_reg;
    assign bus.alu_ctrl   = ctrl_reg;
    assign bus.alu_cmp_en = cmp_reg[1];
    assign bus.alu_eq     = cmp_reg[0];

    assign bus.rsp_result = result_reg;
    assign bus.rsp_zero   = zero_reg;
    assign bus.rsp_err    = err_reg;

endmodule
